dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate data cache that is the responder to the pipeline's EX/MEM data-memory request (MemRead/MemWrite, address, write data). It sits between the CPU's MEM stage and an off-chip data memory. It answers hits in the same cycle. On a miss it stalls the pipeline and runs a write-back/refill handshake with the 256-bit memory port.

---
 rtl/dcache_pkg.sv | 52 +++++
 rtl/dcache_sram.sv | 62 ++++++
 rtl/dcache_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types, geometry constants and address field helpers
//                for the direct-mapped write-back data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int TAG_W      = 22;
    localparam int INDEX_W    = 5;
    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int LINE_W     = 256;
    localparam int NUM_LINES  = 1 << INDEX_W;

    // Controller states; two bits cover all four.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITEBACK   = 2'd1,
        REFILL      = 2'd2,
        REFILL_DONE = 2'd3
    } dcache_state_e;

    // Byte address broken into its cache fields, MSB first.
    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [INDEX_W-1:0]    index;
        logic [WORD_SEL_W-1:0] word;
        logic [1:0]            byte_off;
    } dcache_addr_t;

    // Split a byte address into tag / index / word / byte fields.
    function automatic dcache_addr_t addr_fields(input logic [ADDR_W-1:0] addr);
        return dcache_addr_t'(addr);
    endfunction

    // Rebuild a line-aligned memory address from a tag and an index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

    // Bit position of the least significant bit of a word inside a line.
    function automatic logic [7:0] word_lsb(input logic [WORD_SEL_W-1:0] sel);
        return {sel, 5'b0_0000};
    endfunction

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_sram
//  Description : Tag, valid, dirty and line storage for the data cache.
//                One combinational read port and one synchronous write port
//                (whole-line refill, or single-word store that marks the line
//                dirty). Valid/dirty bits reset; tag and data do not.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    i_index,
    output logic                  o_valid,
    output logic                  o_dirty,
    output logic [TAG_W-1:0]      o_tag,
    output logic [LINE_W-1:0]     o_line,
    input  logic                  i_line_we,
    input  logic [TAG_W-1:0]      i_line_tag,
    input  logic [LINE_W-1:0]     i_line_data,
    input  logic                  i_word_we,
    input  logic [WORD_SEL_W-1:0] i_word_sel,
    input  logic [WORD_W-1:0]     i_word_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];

    // Line state bits: a refill leaves the line clean, a store makes it dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_line_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_index]  <= i_line_tag;
            r_data[i_index] <= i_line_data;
        end else if (i_word_we) begin
            r_data[i_index][word_lsb(i_word_sel) +: WORD_W] <= i_word_data;
        end
    end

endmodule : dcache_sram
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-back, write-allocate data cache between
//                the MEM stage and a 256-bit line memory. Hits complete in the
//                request cycle; misses stall while the victim is written back
//                (if dirty) and the line is refilled.
//                Optional feature macro DCACHE_STATS_EN adds saturating
//                hit_cnt_o / miss_cnt_o counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    dcache_state_e     r_state;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_data;

    dcache_addr_t      w_addr;
    logic [1:0]        w_unused_byte_off;
    logic              w_rd_valid;
    logic              w_rd_dirty;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [LINE_W-1:0] w_rd_line;
    logic              w_hit;
    logic              w_idle;
    logic              w_miss;
    logic              w_store_hit;
    logic              w_refill_we;

    // Address fields; the CPU only issues word-aligned accesses.
    assign w_addr            = addr_fields(p1_addr_i);
    assign w_unused_byte_off = w_addr.byte_off;

    dcache_sram u_sram (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_index     (w_addr.index),
        .o_valid     (w_rd_valid),
        .o_dirty     (w_rd_dirty),
        .o_tag       (w_rd_tag),
        .o_line      (w_rd_line),
        .i_line_we   (w_refill_we),
        .i_line_tag  (w_addr.tag),
        .i_line_data (mem_data_i),
        .i_word_we   (w_store_hit),
        .i_word_sel  (w_addr.word),
        .i_word_data (p1_data_i)
    );

    assign w_hit       = p1_req_i & w_rd_valid & (w_rd_tag == w_addr.tag);
    assign w_idle      = (r_state == IDLE);
    assign w_miss      = w_idle & p1_req_i & ~w_hit;
    // Stores only commit from IDLE; in REFILL_DONE the line matches but the
    // pipeline is still frozen, so the store completes on the following cycle.
    assign w_store_hit = w_idle & w_hit & p1_write_i;
    assign w_refill_we = (r_state == REFILL) & mem_ack_i;

    assign p1_stall_o  = w_miss | ~w_idle;
    assign p1_data_o   = w_hit ? w_rd_line[word_lsb(w_addr.word) +: WORD_W] : '0;

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

    // Miss sequencer with registered memory-port outputs held until ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_mem_enable <= 1'b1;
                        if (w_rd_valid && w_rd_dirty) begin
                            r_state     <= WRITEBACK;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= line_addr(w_rd_tag, w_addr.index);
                            r_mem_data  <= w_rd_line;
                        end else begin
                            r_state     <= REFILL;
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= line_addr(w_addr.tag, w_addr.index);
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state     <= REFILL;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= line_addr(w_addr.tag, w_addr.index);
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        r_state      <= REFILL_DONE;
                        r_mem_enable <= 1'b0;
                    end
                end
                REFILL_DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state      <= IDLE;
                    r_mem_enable <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic        r_after_refill;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

    // Saturating hit/miss counters; the access that completes a miss is not a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_after_refill <= 1'b0;
            r_hit_cnt      <= '0;
            r_miss_cnt     <= '0;
        end else begin
            r_after_refill <= (r_state == REFILL_DONE);
            if (w_idle && w_hit && !r_after_refill && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : dcache_ctrl
`default_nettype wire
